// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - 8-way round-robin arbiter and mux with a registered output slot
// Optional MUX8_ARB_BURST_EN: the current owner keeps winning for up to BURST_MAX loads.
module mux8_rr_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [7:0] in_c,
    input  logic [7:0] in_d,
    input  logic [7:0] in_e,
    input  logic [7:0] in_f,
    input  logic [7:0] in_g,
    input  logic [7:0] in_h,
    output logic [7:0] ack,
    output logic [7:0] out_data,
    output logic [2:0] out_src,
    output logic       out_valid,
    input  logic       out_ready
);
    typedef enum logic {IDLE, FULL} state_t;

    state_t     state, state_next;
    logic [2:0] ptr;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       found;
    logic       load;
    logic [7:0] sel_data;

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        case (winner)
            3'd0:    sel_data = in_a;
            3'd1:    sel_data = in_b;
            3'd2:    sel_data = in_c;
            3'd3:    sel_data = in_d;
            3'd4:    sel_data = in_e;
            3'd5:    sel_data = in_f;
            3'd6:    sel_data = in_g;
            default: sel_data = in_h;
        endcase
    end

    assign load      = (|req) && ((state == IDLE) || out_ready);
    assign out_valid = (state == FULL);

    always_comb begin
        ack = 8'h00;
        if (load && !rst)
            ack[winner] = 1'b1;
    end

    always_comb begin
        state_next = state;
        if (load)
            state_next = FULL;
        else if (state == FULL && out_ready)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

`ifdef MUX8_ARB_BURST_EN
    logic [3:0] burst_cnt;
    logic [3:0] cnt_next;

    // ptr parks on the owner during a burst, so winner == ptr means the owner won again.
    assign cnt_next = ((winner == ptr) ? burst_cnt : 4'd0) + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= 8'h00;
            out_src   <= 3'd0;
            ptr       <= 3'd0;
            burst_cnt <= 4'd0;
        end else if (load) begin
            out_data <= sel_data;
            out_src  <= winner;
            if (cnt_next >= 4'(BURST_MAX)) begin
                ptr       <= winner + 3'd1;
                burst_cnt <= 4'd0;
            end else begin
                ptr       <= winner;
                burst_cnt <= cnt_next;
            end
        end
    end
`else
    wire [3:0] unused_burst_max = 4'(BURST_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= 8'h00;
            out_src  <= 3'd0;
            ptr      <= 3'd0;
        end else if (load) begin
            out_data <= sel_data;
            out_src  <= winner;
            ptr      <= winner + 3'd1;
        end
    end
`endif
endmodule
